// File: rtl/dtc_rx_aligner_if.sv
// Nibble-stream input and assembled-word output bundle of the DTC receive aligner.
// master drives the e-port stream and observes the words; slave is the aligner itself.
interface dtc_rx_aligner_if;
  logic [3:0]  eport_in;
  logic        eport_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_sop;
  logic        word_eop;
  logic        locked;
  logic [15:0] pkt_count;
  logic [7:0]  hdr_err_count;

  modport master (
    output eport_in, eport_valid,
    input  word_out, word_valid, word_sop, word_eop, locked, pkt_count, hdr_err_count
  );

  modport slave (
    input  eport_in, eport_valid,
    output word_out, word_valid, word_sop, word_eop, locked, pkt_count, hdr_err_count
  );
endinterface

// File: rtl/dtc_rx_aligner.sv
// DTC receive aligner: finds the packet header in the nibble stream, qualifies lock over
// several packets and re-assembles 32-bit words with start/end-of-packet flags.
module dtc_rx_aligner #(
  parameter int unsigned PKT_NIBBLES = 64,
  parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_CNT  = 2
) (
  input  logic            clk320,
  input  logic            rst,
  dtc_rx_aligner_if.slave dtc
);
  localparam int unsigned POS_W  = $clog2(PKT_NIBBLES);
  localparam int unsigned WIDX_W = POS_W - 3;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = (UNLOCK_CNT < 2) ? 1 : $clog2(UNLOCK_CNT + 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PKT_NIBBLES - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(PKT_NIBBLES / 8 - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [POS_W-1:0]  r_pos, w_pos_nxt;
  logic [GOOD_W-1:0] r_good, w_good_nxt, w_good_inc;
  logic [MISS_W-1:0] r_miss, w_miss_nxt, w_miss_inc;
  logic              r_emit, w_emit_nxt;
  logic [27:0]       r_shreg;
  logic [31:0]       r_word;
  logic              r_valid, r_sop, r_eop, r_locked;
  logic [15:0]       r_pkt_count;
  logic [7:0]        r_hdr_err;

  logic [15:0]       w_hdr;
  logic              w_hdr_ok, w_at_hdr, w_err_inc, w_word_done;
  logic [WIDX_W-1:0] w_widx;

  // The shift register doubles as header window (low 12 bits) and partial word (all 28).
  assign w_hdr       = {r_shreg[11:0], dtc.eport_in};
  assign w_hdr_ok    = (w_hdr == SYNC_WORD);
  assign w_at_hdr    = (r_pos == POS_W'(3));
  assign w_good_inc  = r_good + 1'b1;
  assign w_miss_inc  = r_miss + 1'b1;
  assign w_widx      = r_pos[POS_W-1:3];
  assign w_word_done = dtc.eport_valid && r_emit && (r_state == ST_LOCKED) && (r_pos[2:0] == 3'd7);

  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_emit_nxt  = r_emit;
    w_err_inc   = 1'b0;
    if (dtc.eport_valid) begin
      w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      unique case (r_state)
        ST_SEARCH: begin
          w_emit_nxt = 1'b0;
          if (w_hdr_ok) begin
            w_state_nxt = ST_VERIFY;
            w_good_nxt  = GOOD_W'(1);
            w_pos_nxt   = POS_W'(4);
          end
        end
        ST_VERIFY: begin
          if (w_at_hdr) begin
            if (w_hdr_ok) begin
              w_good_nxt = w_good_inc;
              // The packet whose header completes lock is emitted in full.
              if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                w_state_nxt = ST_LOCKED;
                w_miss_nxt  = '0;
                w_emit_nxt  = 1'b1;
              end
            end else begin
              w_state_nxt = ST_SEARCH;
              w_good_nxt  = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_at_hdr) begin
            if (w_hdr_ok) begin
              w_miss_nxt = '0;
              w_emit_nxt = 1'b1;
            end else begin
              w_miss_nxt = w_miss_inc;
              w_emit_nxt = 1'b0;
              w_err_inc  = 1'b1;
              if (w_miss_inc == MISS_W'(UNLOCK_CNT)) begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = '0;
              end
            end
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk320) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_pos       <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_emit      <= 1'b0;
      r_shreg     <= '0;
      r_word      <= '0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_locked    <= 1'b0;
      r_pkt_count <= '0;
      r_hdr_err   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_good   <= w_good_nxt;
      r_miss   <= w_miss_nxt;
      r_emit   <= w_emit_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_valid  <= w_word_done;
      r_sop    <= w_word_done && (w_widx == '0);
      r_eop    <= w_word_done && (w_widx == WIDX_LAST);
      if (dtc.eport_valid)
        r_shreg <= {r_shreg[23:0], dtc.eport_in};
      if (w_word_done)
        r_word <= {r_shreg, dtc.eport_in};
      if (w_word_done && (w_widx == WIDX_LAST))
        r_pkt_count <= r_pkt_count + 1'b1;
      if (w_err_inc && (r_hdr_err != 8'hFF))
        r_hdr_err <= r_hdr_err + 1'b1;
    end
  end

  assign dtc.word_out      = r_word;
  assign dtc.word_valid    = r_valid;
  assign dtc.word_sop      = r_sop;
  assign dtc.word_eop      = r_eop;
  assign dtc.locked        = r_locked;
  assign dtc.pkt_count     = r_pkt_count;
  assign dtc.hdr_err_count = r_hdr_err;
endmodule
